// File: rtl/downcnt_pkg.sv
// rtl/downcnt_pkg.sv - shared constants for the down counter
package downcnt_pkg;

  localparam int           DOWNCNT_WIDTH_DEF = 3;
  localparam logic         DOWNCNT_RST_BIT   = 1'b1;
  localparam logic [2:0]   DOWNCNT_RST_VAL   = {DOWNCNT_WIDTH_DEF{DOWNCNT_RST_BIT}};

endpackage

// File: rtl/tg_dff.sv
// rtl/tg_dff.sv - one-bit master-slave transmission-gate D flip-flop, synchronous reset
// Modelled at the behavioural level; the cell library maps it onto the TG master/slave pair.
module tg_dff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= RST_VAL;
    end else begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/down_counter.sv
// rtl/down_counter.sv - loadable down counter with wrap borrow pulse (DOWNCNT_SATURATE_EN: hold at zero)
module down_counter
  import downcnt_pkg::*;
#(
  parameter int WIDTH = DOWNCNT_WIDTH_DEF
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             En,
  input  logic             Load,
  input  logic [WIDTH-1:0] LdVal,
  output logic [WIDTH-1:0] Q,
  output logic             Zero,
  output logic             Borrow
);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_q_d;
  logic [WIDTH-1:0] w_dec;
  logic             w_wrap;
  logic             w_dec_en;
  logic             w_borrow_q;
  logic             w_borrow_d;

  assign w_dec_en = En & ~Load;

  // Ripple borrow: bit i toggles when every lower bit is zero; the final borrow marks 0 -> all-ones.
  always_comb begin
    logic w_chain;
    w_chain = 1'b1;
    w_dec   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_dec[i] = w_q[i] ^ w_chain;
      w_chain  = w_chain & ~w_q[i];
    end
    w_wrap = w_chain;
  end

  always_comb begin
    w_q_d      = w_q;
    w_borrow_d = 1'b0;
    if (Load) begin
      w_q_d = LdVal;
    end else if (En) begin
`ifdef DOWNCNT_SATURATE_EN
      w_q_d = w_wrap ? w_q : w_dec;
`else
      w_q_d      = w_dec;
      w_borrow_d = w_dec_en & w_wrap;
`endif
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_q_bit
    tg_dff #(
      .RST_VAL(DOWNCNT_RST_BIT)
    ) u_q_dff (
      .i_clk(Clk),
      .i_rst(Rst),
      .i_d  (w_q_d[g]),
      .o_q  (w_q[g])
    );
  end

  tg_dff #(
    .RST_VAL(1'b0)
  ) u_borrow_dff (
    .i_clk(Clk),
    .i_rst(Rst),
    .i_d  (w_borrow_d),
    .o_q  (w_borrow_q)
  );

  assign Q      = w_q;
  assign Borrow = w_borrow_q;
  assign Zero   = (w_q == '0);

endmodule

// File: tb/tb_down_counter.sv
// tb/tb_down_counter.sv - directed self-checking bench for down_counter
module tb_down_counter;

  logic       Clk;
  logic       Rst;
  logic       En;
  logic       Load;
  logic [2:0] LdVal;
  logic [2:0] Q;
  logic       Zero;
  logic       Borrow;

  int total;
  int bad;

  down_counter #(.WIDTH(3)) dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .En    (En),
    .Load  (Load),
    .LdVal (LdVal),
    .Q     (Q),
    .Zero  (Zero),
    .Borrow(Borrow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int q_e, input int z_e, input int b_e);
    check({tag, ".q"}, int'(Q), q_e);
    check({tag, ".zero"}, int'(Zero), z_e);
    check({tag, ".borrow"}, int'(Borrow), b_e);
  endtask

  int q_run[8] = '{6, 5, 4, 3, 2, 1, 0, 7};
  int z_run[8] = '{0, 0, 0, 0, 0, 0, 1, 0};
  int b_run[8] = '{0, 0, 0, 0, 0, 0, 0, 1};
  int borrows;

  initial begin
    total = 0;
    bad   = 0;
    Rst   = 1'b1;
    En    = 1'b1;
    Load  = 1'b0;
    LdVal = 3'd0;

    tick();
    check_all("rst0", 7, 0, 0);
    tick();
    check_all("rst1", 7, 0, 0);

    Rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_all($sformatf("run%0d", i), q_run[i], z_run[i], b_run[i]);
    end
    tick();
    check_all("run_after_wrap", 6, 0, 0);

    Load  = 1'b1;
    LdVal = 3'd2;
    tick();
    check_all("load_prio", 2, 0, 0);
    Load = 1'b0;
    tick();
    check_all("load_dec1", 1, 0, 0);
    tick();
    check_all("load_dec0", 0, 1, 0);

    Load  = 1'b1;
    LdVal = 3'd7;
    tick();
    check_all("load_ones", 7, 0, 0);

    LdVal = 3'd0;
    tick();
    check_all("load_zero", 0, 1, 0);

    Load = 1'b0;
    En   = 1'b0;
    tick();
    check_all("hold0", 0, 1, 0);
    tick();
    check_all("hold1", 0, 1, 0);

    En  = 1'b1;
    Rst = 1'b1;
    tick();
    check_all("rst_mid", 7, 0, 0);
    Load  = 1'b1;
    LdVal = 3'd2;
    tick();
    check_all("rst_ignore_load", 7, 0, 0);

    Rst   = 1'b0;
    LdVal = 3'd3;
    tick();
    check_all("post_rst_load", 3, 0, 0);

    LdVal = 3'd1;
    tick();
    check_all("sat_load", 1, 0, 0);
    Load = 1'b0;
`ifdef DOWNCNT_SATURATE_EN
    tick();
    check_all("sat0", 0, 1, 0);
    tick();
    check_all("sat1", 0, 1, 0);
    tick();
    check_all("sat2", 0, 1, 0);
`else
    tick();
    check_all("wrap0", 0, 1, 0);
    tick();
    check_all("wrap1", 7, 0, 1);
    tick();
    check_all("wrap2", 6, 0, 0);
`endif

    Load  = 1'b1;
    LdVal = 3'd5;
    tick();
    check_all("load_after", 5, 0, 0);

    Load  = 1'b0;
    LdVal = 3'd7;
    Load  = 1'b1;
    tick();
    Load    = 1'b0;
    borrows = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (Borrow) borrows++;
    end
`ifdef DOWNCNT_SATURATE_EN
    check("borrow_count", borrows, 0);
    check_all("period_end", 0, 1, 0);
`else
    check("borrow_count", borrows, 2);
    check_all("period_end", 7, 0, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
